// File: rtl/rsenc_stream.sv
`default_nettype none
// ============================================================================
// Module   : rsenc_stream
// Purpose  : Streaming systematic Reed-Solomon encoder over GF(2^8)
//            (field polynomial x^8+x^7+x^2+x+1, alpha = 0x02), 4 parity
//            symbols, g(x) = (x+a)(x+a^2)(x+a^3)(x+a^4)
//                   = x^4 + 1E x^3 + D8 x^2 + CE x + 95.
//            Message bytes pass through unchanged, followed by the four
//            remainder bytes (highest degree first), with valid/ready flow
//            control on both sides and a single output register stage.
// Ports    : clk        rising-edge clock
//            clrn       asynchronous active-low reset
//            in_valid   in_data carries a message byte
//            in_ready   encoder takes in_data this cycle
//            in_data    message symbol, highest-degree coefficient first
//            out_valid  out_data valid
//            out_ready  downstream takes out_data this cycle
//            out_data   codeword symbol
//            out_par    out_data is a parity symbol
//            out_last   out_data is the last symbol of the codeword
//            abort      (RSENC_ABORT_EN only) drop the current frame
// Config   : MSG_LEN         message symbols per codeword (1..251)
//            RSENC_ABORT_EN  define to add the synchronous abort input
// Revision : 1.0 - initial release
// ============================================================================
module rsenc_stream #(
  parameter int MSG_LEN = 251
) (
  input  logic       clk,
  input  logic       clrn,
`ifdef RSENC_ABORT_EN
  input  logic       abort,
`endif
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_par,
  output logic       out_last
);

  localparam logic [0:0] ST_MSG   = 1'b0;
  localparam logic [0:0] ST_PAR   = 1'b1;

  localparam logic [7:0] LAST_MSG = 8'(MSG_LEN - 1);
  localparam logic [7:0] LAST_PAR = 8'd3;

  // Constant multipliers as linear maps: byte k of each table is
  // g_i * alpha^k, so g_i * x is the XOR of the columns selected by x's bits.
  //                                    a^7    a^6    a^5    a^4    a^3    a^2    a^1    a^0
  localparam logic [63:0] G3_COLS = {8'h36, 8'h1B, 8'hCE, 8'h67, 8'hF0, 8'h78, 8'h3C, 8'h1E};
  localparam logic [63:0] G2_COLS = {8'h7F, 8'hFC, 8'h7E, 8'h3F, 8'hDC, 8'h6E, 8'h37, 8'hD8};
  localparam logic [63:0] G1_COLS = {8'hDC, 8'h6E, 8'h37, 8'hD8, 8'h6C, 8'h36, 8'h1B, 8'hCE};
  localparam logic [63:0] G0_COLS = {8'hDE, 8'h6F, 8'hF4, 8'h7A, 8'h3D, 8'hDD, 8'hAD, 8'h95};

  function automatic logic [7:0] gf_mul_const(input logic [63:0] cols, input logic [7:0] x);
    logic [7:0] acc;
    acc = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (x[i]) acc = acc ^ cols[8*i +: 8];
    end
    return acc;
  endfunction

  logic [0:0] state;
  logic [0:0] state_nxt;
  logic [7:0] r3, r2, r1, r0;
  logic [7:0] cnt;

  logic       free;
  logic       accept;
  logic       par_issue;
  logic       kill;
  logic [7:0] fb;
  logic [7:0] fb_g3, fb_g2, fb_g1, fb_g0;

`ifdef RSENC_ABORT_EN
  assign kill = abort;
`else
  assign kill = 1'b0;
`endif

  // Feedback term of the division LFSR and its four constant products.
  assign fb    = in_data ^ r3;
  assign fb_g3 = gf_mul_const(G3_COLS, fb);
  assign fb_g2 = gf_mul_const(G2_COLS, fb);
  assign fb_g1 = gf_mul_const(G1_COLS, fb);
  assign fb_g0 = gf_mul_const(G0_COLS, fb);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state <= ST_MSG;
    end else begin
      state <= state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    if (kill) begin
      state_nxt = ST_MSG;
    end else begin
      case (state)
        ST_MSG:  if (accept && (cnt == LAST_MSG)) state_nxt = ST_PAR;
        ST_PAR:  if (par_issue && (cnt == LAST_PAR)) state_nxt = ST_MSG;
        default: state_nxt = ST_MSG;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // FSM: outputs / handshake decode
  // The output register may be refilled whenever it is empty or being
  // drained this cycle; in_ready deliberately ignores in_valid.
  // --------------------------------------------------------------------------
  always_comb begin
    free      = !out_valid | out_ready;
    in_ready  = (state == ST_MSG) & free;
    accept    = in_valid & in_ready & !kill;
    par_issue = (state == ST_PAR) & free & !kill;
  end

  // --------------------------------------------------------------------------
  // Datapath: LFSR, symbol counter and output register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r3        <= 8'h00;
      r2        <= 8'h00;
      r1        <= 8'h00;
      r0        <= 8'h00;
      cnt       <= 8'h00;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      out_par   <= 1'b0;
      out_last  <= 1'b0;
    end else if (kill) begin
      // Abort wins over everything, including a stalled output symbol.
      r3        <= 8'h00;
      r2        <= 8'h00;
      r1        <= 8'h00;
      r0        <= 8'h00;
      cnt       <= 8'h00;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      out_par   <= 1'b0;
      out_last  <= 1'b0;
    end else if (accept) begin
      r3        <= r2 ^ fb_g3;
      r2        <= r1 ^ fb_g2;
      r1        <= r0 ^ fb_g1;
      r0        <= fb_g0;
      out_valid <= 1'b1;
      out_data  <= in_data;
      out_par   <= 1'b0;
      out_last  <= 1'b0;
      cnt       <= (cnt == LAST_MSG) ? 8'h00 : cnt + 8'd1;
    end else if (par_issue) begin
      // Shift the remainder out r3 first; zero-fill leaves the LFSR clear
      // after the fourth symbol so the next frame can start immediately.
      r3        <= r2;
      r2        <= r1;
      r1        <= r0;
      r0        <= 8'h00;
      out_valid <= 1'b1;
      out_data  <= r3;
      out_par   <= 1'b1;
      out_last  <= (cnt == LAST_PAR);
      cnt       <= (cnt == LAST_PAR) ? 8'h00 : cnt + 8'd1;
    end else if (free) begin
      // Slot drained with nothing new to place in it.
      out_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: doc/rsenc_stream.md
Name: rsenc_stream

Overview:
- Streaming systematic Reed-Solomon encoder over GF(2^8); transmit-side counterpart of the decoder's syndrome generator (rsdec_syn).
- Same field: primitive polynomial x^8+x^7+x^2+x+1.
- Same code: 4 parity symbols, generator g(x) = (x+α)(x+α^2)(x+α^3)(x+α^4), α = 0x02.
- Accepts message bytes over a valid/ready stream and emits message bytes unchanged, then 4 parity bytes, with backpressure.

Parameters:
- MSG_LEN, 251, message symbols per codeword (1..251); codeword length is MSG_LEN+4.

Ports:
- clk  input  1  clock, rising edge.
- clrn  input  1  asynchronous active-low reset.
- in_valid  input  1  in_data holds a valid message byte.
- in_ready  output  1  encoder accepts in_data this cycle.
- in_data  input  8  message symbol, first symbol = highest-degree coefficient.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_data  output  8  codeword symbol.
- out_par  output  1  out_data is a parity symbol.
- out_last  output  1  out_data is the final symbol of the codeword.
- abort  input  1  present only with RSENC_ABORT_EN.

Behaviour:
- Constants: g3..g0 are the coefficients of g(x) = x^4 + g3x^3 + g2x^2 + g1x + g0. They are hard-coded as constant GF multipliers (XOR networks), computed offline.
- State: 4x8-bit LFSR r3..r0, 8-bit symbol counter cnt, 2-state FSM MSG/PAR, 1-entry output register (out_valid/out_data/out_par/out_last).
- Output slot free: free = !out_valid | out_ready.
- in_ready = (state==MSG) & free. It is combinational and does not depend on in_valid.
- Accept: accept = in_valid & in_ready. On accept:
  - fb = in_data ^ r3
  - r3 <= r2 ^ g3·fb, r2 <= r1 ^ g2·fb, r1 <= r0 ^ g1·fb, r0 <= g0·fb
  - out_data <= in_data, out_valid <= 1, out_par <= 0, out_last <= 0
  - cnt <= cnt+1
  - When cnt==MSG_LEN-1: cnt <= 0, state <= PAR.
- PAR state, each cycle with free high:
  - out_data <= r3, out_par <= 1, out_valid <= 1
  - shift: r3 <= r2, r2 <= r1, r1 <= r0, r0 <= 0
  - cnt <= cnt+1
  - When cnt==3: out_last <= 1, cnt <= 0, LFSR already zero, state <= MSG.
- Parity order: r3 first, r0 last.
- Free but no new symbol (MSG state, no accept): out_valid <= 0.
- Latency: one cycle from input accept (or parity issue) to out_valid. Full throughput: one symbol per cycle when out_ready is held high.
- Back-to-back frames: the first byte of the next frame may be accepted in the cycle after the last parity symbol is issued. No bubble is required beyond the 4 parity cycles.
- Backpressure: while out_valid & !out_ready, all state and outputs hold. No symbol is dropped or duplicated.
- Reset (async, any time, including mid-frame): r3..r0=0, cnt=0, state=MSG, out_valid=0, out_data=0, out_par=0, out_last=0. in_ready is 1 after reset deassertion. A partially received frame is discarded.
- MSG_LEN=1 is legal: PAR is entered right after the first accept.

Optional Feature:
- RSENC_ABORT_EN defined:
  - The abort port exists.
  - abort high at a rising edge clears LFSR, cnt and FSM (to MSG) and sets out_valid=0. abort has priority over accept and parity issue.
  - The output register is cleared even under backpressure.
- RSENC_ABORT_EN undefined: no abort port; the only way to discard a frame is clrn.

Test Plan:
- 251 × 0x00, out_ready=1 → 255 × 0x00 on consecutive cycles; out_par high for symbols 252..255; out_last only on symbol 255; in_ready low for exactly 4 cycles.
- 250 × 0x00 then 0x01 → parity bytes equal g3, g2, g1, g0 in that order.
- Random 251-byte message → feeding the 255 output bytes through rsdec_syn gives y0=y1=y2=y3=0x00; message bytes appear bit-exact.
- Same random message with out_ready toggling pseudo-randomly and in_valid gapped → output symbol sequence identical to the ungated run; out_data held stable while out_valid & !out_ready.
- out_ready held 0 for 10 cycles at the first parity symbol → out_data, out_par=1 and the LFSR hold; in_ready=0 throughout; the sequence resumes correctly.
- clrn pulsed after 100 accepted bytes → all outputs 0 asynchronously. The following full frame encodes correctly (syndromes zero). With RSENC_ABORT_EN, abort at byte 50 gives the same result.
